// File: rtl/manchester_rx_frame_pkg.sv
// Shared types and constants for the Manchester frame receiver.
package manchester_rx_frame_pkg;

  localparam int unsigned STATE_W = 3;
  localparam int unsigned CODE_W  = 2;

  localparam logic [STATE_W-1:0] IDLE   = 3'd0;
  localparam logic [STATE_W-1:0] START  = 3'd1;
  localparam logic [STATE_W-1:0] DATA   = 3'd2;
  localparam logic [STATE_W-1:0] PARITY = 3'd3;
  localparam logic [STATE_W-1:0] STOP   = 3'd4;

  localparam logic [CODE_W-1:0] ERR_NONE   = 2'd0;
  localparam logic [CODE_W-1:0] ERR_MANCH  = 2'd1;
  localparam logic [CODE_W-1:0] ERR_NOEDGE = 2'd2;
  localparam logic [CODE_W-1:0] ERR_FRAME  = 2'd3;

  // Mid-bit verdict: a missing resync edge outranks equal half-bit levels.
  function automatic logic [CODE_W-1:0] bit_check(input logic edge_seen,
                                                  input logic s1,
                                                  input logic s2);
    logic [CODE_W-1:0] code;
    code = ERR_NONE;
    if (!edge_seen) begin
      code = ERR_NOEDGE;
    end else if (s1 == s2) begin
      code = ERR_MANCH;
    end
    return code;
  endfunction

endpackage

// File: rtl/manchester_rx_if.sv
// Pin-side and parallel-side signals of the Manchester frame receiver.
interface manchester_rx_if #(
  parameter int unsigned WIDTH = 16
);
  logic             data_in;
  logic [WIDTH-1:0] data_out;
  logic             valid;
  logic             error;
  logic [1:0]       error_code;
  logic             busy;

  modport master (
    output data_in,
    input  data_out, valid, error, error_code, busy
  );

  modport slave (
    input  data_in,
    output data_out, valid, error, error_code, busy
  );
endinterface

// File: rtl/manchester_rx_sync.sv
// Two-flop synchroniser for an asynchronous pin plus an edge-detect stage.
module manchester_rx_sync (
  input  logic clk,
  input  logic rst,
  input  logic din,
  output logic level,
  output logic rise_c,
  output logic fall_c,
  output logic any_c
);

  logic [2:0] sr;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sr <= '0;
    end else begin
      sr <= {sr[1:0], din};
    end
  end

  assign level  = sr[1];
  assign rise_c = sr[1] & ~sr[2];
  assign fall_c = ~sr[1] & sr[2];
  assign any_c  = sr[1] ^ sr[2];

endmodule

// File: rtl/manchester_rx_frame.sv
// Self-clocked Manchester frame receiver: start bit, WIDTH data bits MSB first, stop bit.
// Optional even-parity bit before the stop bit when MANCHESTER_RX_PARITY_EN is defined.
module manchester_rx_frame
  import manchester_rx_frame_pkg::*;
#(
  parameter int unsigned HALF_BIT = 8,
  parameter int unsigned WIDTH    = 16
) (
  input  logic            clk,
  input  logic            rst,
  manchester_rx_if.slave  bus
);

  localparam int unsigned CNT_W   = $clog2(2 * HALF_BIT);
  localparam int unsigned CNT_MAX = 2 * HALF_BIT - 1;
  localparam int unsigned S1_POS  = HALF_BIT / 2;
  localparam int unsigned S2_POS  = (3 * HALF_BIT) / 2;
  localparam int unsigned W_LO    = HALF_BIT / 2;
  localparam int unsigned W_HI    = (3 * HALF_BIT) / 2 - 1;
  localparam int unsigned BIT_W   = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  logic sl;
  logic rise_c;
  logic any_c;
  logic unused_fall;

  manchester_rx_sync u_sync (
    .clk    (clk),
    .rst    (rst),
    .din    (bus.data_in),
    .level  (sl),
    .rise_c (rise_c),
    .fall_c (unused_fall),
    .any_c  (any_c)
  );

  logic [STATE_W-1:0] state,      state_d;
  logic [CNT_W-1:0]   cnt,        cnt_d;
  logic [BIT_W-1:0]   bitcnt,     bitcnt_d;
  logic               edge_seen,  edge_seen_d;
  logic               s1,         s1_d;
  logic [WIDTH-1:0]   shreg,      shreg_d;
  logic [WIDTH-1:0]   data_out_q, data_out_d;
  logic               valid_q,    valid_d;
  logic               error_q,    error_d;
  logic [CODE_W-1:0]  code_q,     code_d;
  logic               busy_q,     busy_d;

  logic              at_s1;
  logic              at_s2;
  logic              wrap;
  logic              in_win;
  logic [CODE_W-1:0] verdict;

  assign at_s1   = (cnt == CNT_W'(S1_POS));
  assign at_s2   = (cnt == CNT_W'(S2_POS));
  assign wrap    = (cnt == CNT_W'(CNT_MAX));
  assign in_win  = (cnt >= CNT_W'(W_LO)) && (cnt <= CNT_W'(W_HI));
  assign verdict = bit_check(edge_seen, s1, sl);

  // State and datapath register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      cnt        <= '0;
      bitcnt     <= '0;
      edge_seen  <= 1'b0;
      s1         <= 1'b0;
      shreg      <= '0;
      data_out_q <= '0;
      valid_q    <= 1'b0;
      error_q    <= 1'b0;
      code_q     <= ERR_NONE;
      busy_q     <= 1'b0;
    end else begin
      state      <= state_d;
      cnt        <= cnt_d;
      bitcnt     <= bitcnt_d;
      edge_seen  <= edge_seen_d;
      s1         <= s1_d;
      shreg      <= shreg_d;
      data_out_q <= data_out_d;
      valid_q    <= valid_d;
      error_q    <= error_d;
      code_q     <= code_d;
      busy_q     <= busy_d;
    end
  end

  // Next-state, bit-phase tracking and output decode
  always_comb begin
    state_d     = state;
    cnt_d       = cnt;
    bitcnt_d    = bitcnt;
    edge_seen_d = edge_seen;
    s1_d        = s1;
    shreg_d     = shreg;
    data_out_d  = data_out_q;
    valid_d     = 1'b0;
    error_d     = 1'b0;
    code_d      = code_q;

    if (state != IDLE) begin
      cnt_d = wrap ? '0 : cnt + CNT_W'(1);
      // Only mid-bit edges steer the phase; boundary edges fall outside the window.
      if (any_c && in_win) begin
        cnt_d       = CNT_W'(HALF_BIT);
        edge_seen_d = 1'b1;
      end
      if (at_s1) begin
        s1_d = sl;
      end
      if (at_s2) begin
        edge_seen_d = 1'b0;
      end
    end

    case (state)
      IDLE: begin
        cnt_d       = '0;
        edge_seen_d = 1'b0;
        if (rise_c) begin
          state_d = START;
        end
      end

      START: begin
        // A start bit that does not decode to 1 is treated as line noise.
        if (at_s2 && ((verdict != ERR_NONE) || !s1)) begin
          state_d = IDLE;
        end else if (wrap) begin
          state_d  = DATA;
          bitcnt_d = '0;
        end
      end

      DATA: begin
        if (at_s2) begin
          if (verdict != ERR_NONE) begin
            error_d = 1'b1;
            code_d  = verdict;
            state_d = IDLE;
          end else begin
            shreg_d = WIDTH'({shreg, s1});
          end
        end else if (wrap) begin
          if (bitcnt == BIT_W'(WIDTH - 1)) begin
`ifdef MANCHESTER_RX_PARITY_EN
            state_d = PARITY;
`else
            state_d = STOP;
`endif
          end else begin
            bitcnt_d = bitcnt + BIT_W'(1);
          end
        end
      end

`ifdef MANCHESTER_RX_PARITY_EN
      PARITY: begin
        if (at_s2) begin
          if (verdict != ERR_NONE) begin
            error_d = 1'b1;
            code_d  = verdict;
            state_d = IDLE;
          end else if ((^shreg) ^ s1) begin
            error_d = 1'b1;
            code_d  = ERR_FRAME;
            state_d = IDLE;
          end
        end else if (wrap) begin
          state_d = STOP;
        end
      end
`endif

      STOP: begin
        if (at_s2) begin
          if (s1 || sl) begin
            error_d = 1'b1;
            code_d  = ERR_FRAME;
            state_d = IDLE;
          end
        end else if (wrap || (rise_c && (cnt > CNT_W'(S2_POS)))) begin
          // A start edge landing on the stop wrap begins the next frame at once.
          valid_d     = 1'b1;
          data_out_d  = shreg;
          state_d     = rise_c ? START : IDLE;
          cnt_d       = '0;
          edge_seen_d = 1'b0;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase

    busy_d = (state_d != IDLE);
  end

  assign bus.data_out   = data_out_q;
  assign bus.valid      = valid_q;
  assign bus.error      = error_q;
  assign bus.error_code = code_q;
  assign bus.busy       = busy_q;

endmodule

// File: tb/tb_manchester_rx_frame.sv
// Directed scoreboard bench for manchester_rx_frame (HALF_BIT = 8, WIDTH = 16).
module tb_manchester_rx_frame;

  localparam int unsigned HALF_BIT = 8;
  localparam int unsigned WIDTH    = 16;
  localparam int          HALF_NS  = 10 * HALF_BIT;
  localparam int          SLOW_NS  = 88;
`ifdef MANCHESTER_RX_PARITY_EN
  localparam bit PAR_EN = 1'b1;
`else
  localparam bit PAR_EN = 1'b0;
`endif

  typedef struct {
    bit               is_err;
    logic [WIDTH-1:0] data;
    logic [1:0]       code;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;

  manchester_rx_if #(.WIDTH(WIDTH)) bus ();

  manchester_rx_frame #(.HALF_BIT(HALF_BIT), .WIDTH(WIDTH)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  exp_t             sb[$];
  exp_t             mon_e;
  logic             halves[$];
  logic [WIDTH-1:0] last_good = '0;
  int               n_checks  = 0;
  int               n_pass    = 0;
  int               n_fail    = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic int auto_par(input logic [WIDTH-1:0] d);
    return PAR_EN ? int'(^d) : -1;
  endfunction

  task automatic add_bit(input logic b);
    halves.push_back(b);
    halves.push_back(~b);
  endtask

  // Start bit, data MSB first, optional parity bit, low stop interval.
  task automatic build(input logic [WIDTH-1:0] d, input int par);
    halves.delete();
    add_bit(1'b1);
    for (int i = WIDTH - 1; i >= 0; i--) add_bit(d[i]);
    if (par >= 0) add_bit(par[0]);
    halves.push_back(1'b0);
    halves.push_back(1'b0);
  endtask

  task automatic send(input int half_ns);
    foreach (halves[i]) begin
      bus.data_in = halves[i];
      #(half_ns);
    end
    bus.data_in = 1'b0;
  endtask

  task automatic expect_valid(input logic [WIDTH-1:0] d);
    exp_t e;
    e.is_err = 1'b0; e.data = d; e.code = 2'd0;
    sb.push_back(e);
  endtask

  task automatic expect_error(input logic [1:0] c);
    exp_t e;
    e.is_err = 1'b1; e.data = '0; e.code = c;
    sb.push_back(e);
  endtask

  task automatic drain(input string tag, input int budget);
    int k;
    k = 0;
    while (sb.size() != 0 && k < budget) begin
      @(negedge clk);
      k++;
    end
    chk(tag, sb.size(), 0);
    repeat (2) @(negedge clk);
    chk({tag, "_busy"}, bus.busy, 1'b0);
  endtask

  // Output monitor: every pulse must match the head of the scoreboard.
  always @(negedge clk) begin
    if (!rst && (bus.valid || bus.error)) begin
      chk("excl", bus.valid & bus.error, 0);
      if (sb.size() == 0) begin
        chk("spurious", {bus.valid, bus.error}, 0);
      end else begin
        mon_e = sb.pop_front();
        chk("kind_err", bus.error, mon_e.is_err);
        if (mon_e.is_err) begin
          chk("err_code", bus.error_code, mon_e.code);
          chk("held_data", bus.data_out, last_good);
        end else begin
          chk("data", bus.data_out, mon_e.data);
          last_good = mon_e.data;
        end
      end
    end
  end

  initial begin
    bus.data_in = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_data", bus.data_out, 0);
    chk("rst_valid", bus.valid, 0);
    chk("rst_error", bus.error, 0);
    chk("rst_code", bus.error_code, 0);
    chk("rst_busy", bus.busy, 0);
    rst = 1'b0;
    repeat (5) @(negedge clk);

    // Ideal timing
    expect_valid(16'hA5C3);
    build(16'hA5C3, auto_par(16'hA5C3));
    send(HALF_NS);
    drain("ideal", 60);

    // Bit period stretched by 10 percent
    @(negedge clk);
    expect_valid(16'h1234);
    build(16'h1234, auto_par(16'h1234));
    send(SLOW_NS);
    drain("slow", 60);

    // Data bit 5 without a mid-bit transition, line idles afterwards
    @(negedge clk);
    expect_error(2'd2);
    build(16'h5A5A, auto_par(16'h5A5A));
    halves[2 * 6 + 1] = halves[2 * 6];
    while (halves.size() > 2 * 6 + 2) void'(halves.pop_back());
    send(HALF_NS);
    drain("noedge", 60);
    chk("noedge_code_held", bus.error_code, 2);

    @(negedge clk);
    expect_valid(16'h00FF);
    build(16'h00FF, auto_par(16'h00FF));
    send(HALF_NS);
    drain("after_err", 60);

    // Three-cycle glitch on an idle line
    @(negedge clk);
    bus.data_in = 1'b1;
    repeat (3) @(negedge clk);
    bus.data_in = 1'b0;
    chk("glitch_busy_hi", bus.busy, 1);
    repeat (2 * HALF_BIT) @(negedge clk);
    chk("glitch_busy_lo", bus.busy, 0);
    chk("glitch_sb", sb.size(), 0);

    // Back-to-back frames with no idle gap
    @(negedge clk);
    expect_valid(16'h8001);
    expect_valid(16'h7FFE);
    build(16'h8001, auto_par(16'h8001));
    send(HALF_NS);
    build(16'h7FFE, auto_par(16'h7FFE));
    send(HALF_NS);
    drain("b2b", 60);

    // Line held high through the stop interval
    @(negedge clk);
    expect_error(2'd3);
    build(16'h0F0F, auto_par(16'h0F0F));
    halves[halves.size() - 2] = 1'b1;
    halves[halves.size() - 1] = 1'b1;
    send(HALF_NS);
    drain("stop_high", 60);
    chk("stop_code_held", bus.error_code, 3);

`ifdef MANCHESTER_RX_PARITY_EN
    @(negedge clk);
    expect_valid(16'h0001);
    build(16'h0001, 1);
    send(HALF_NS);
    drain("par_ok", 60);

    @(negedge clk);
    expect_error(2'd3);
    build(16'h0001, 0);
    send(HALF_NS);
    drain("par_bad", 60);
`endif

    // Reset in the middle of a frame
    @(negedge clk);
    build(16'h3C3C, auto_par(16'h3C3C));
    while (halves.size() > 10) void'(halves.pop_back());
    send(HALF_NS);
    chk("mid_busy", bus.busy, 1);
    rst = 1'b1;
    #1;
    chk("mid_rst_data", bus.data_out, 0);
    chk("mid_rst_valid", bus.valid, 0);
    chk("mid_rst_error", bus.error, 0);
    chk("mid_rst_code", bus.error_code, 0);
    chk("mid_rst_busy", bus.busy, 0);
    repeat (3) @(negedge clk);
    rst = 1'b0;
    last_good = '0;
    repeat (4 * HALF_BIT) @(negedge clk);
    chk("post_rst_busy", bus.busy, 0);
    chk("post_rst_data", bus.data_out, 0);
    chk("post_rst_sb", sb.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/manchester_rx_frame.md
Name: manchester_rx_frame

Overview:
- Self-clocked single-wire Manchester frame receiver. There is no companion clock line: bit timing is recovered from mid-bit transitions using the system clock.
- Deserialises a start bit, WIDTH data bits (MSB first) and a stop interval into a parallel word, with valid and error pulses.
- Sits behind a pin input on the FPGA side of a single-wire link. Bit convention: first half-bit carries the data level, second half carries its inverse.

Parameters:
- HALF_BIT, 8, clk cycles per half-bit; minimum 4, must be even.
- WIDTH, 16, data bits per frame; range 1..32.

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous, active-high reset.
- data_in  in  1  raw Manchester line, asynchronous to clk; idle level is low.
- data_out  out  WIDTH  last correctly received word; updates only when valid pulses.
- valid  out  1  one-cycle pulse; data_out is new.
- error  out  1  one-cycle pulse; frame rejected.
- error_code  out  2  reason for the last error; held until the next error or reset. 1 = Manchester violation, 2 = missing mid-bit edge, 3 = stop/parity fault.
- busy  out  1  high while state is not IDLE.

Behaviour:
- Reset: all outputs 0, state IDLE, counters 0. Reset mid-frame aborts the frame with no valid and no error.
- Input path: data_in passes through a 2-FF synchroniser plus a third register for edge detection. All timing below refers to the synchronised line (sl).
- Phase counter cnt runs 0..2*HALF_BIT-1, one step per clk; wrapping to 0 ends a bit.
- Mid-bit window W spans cnt in [HALF_BIT/2, 3*HALF_BIT/2-1].
- Resync: an sl edge inside W sets cnt to HALF_BIT and sets edge_seen. Edges outside W (bit-boundary edges between equal bits) are ignored.
- Sampling: s1 = sl at cnt = HALF_BIT/2; s2 = sl at cnt = 3*HALF_BIT/2.
- At cnt = 3*HALF_BIT/2, checks run in this priority:
  - edge_seen = 0 gives code 2.
  - else s1 == s2 gives code 1.
  - else bit = s1.
  - edge_seen is then cleared.
- States:
  - IDLE: on an sl rising edge, set cnt = 0 and go to START.
  - START: the bit must decode to 1. Any failure returns to IDLE silently (glitch rejection, no error pulse). On wrap, go to DATA with bitcnt = 0.
  - DATA: shift the decoded bit into the shift register MSB-first. A failure gives an error pulse with the relevant code, then IDLE. After bit WIDTH-1 wraps, go to PARITY (if enabled) or STOP.
  - STOP: one full bit time. s1 and s2 must both be 0, otherwise code 3. On wrap: if no fault, data_out <= shift register and valid pulses; then IDLE.
- Latency: valid asserts on the clk cycle after the STOP wrap, i.e. about 3 sync cycles + (WIDTH+2)*2*HALF_BIT cycles after the leading rising edge of the start bit on data_in.
- error and valid are never high together. error_code changes only on an error pulse.
- A line stuck high after an error does not start a new frame; a rising edge is required.
- Back-to-back frames: the next rising edge is accepted on the first IDLE cycle.

Optional Feature:
- Macro: MANCHESTER_RX_PARITY_EN.
- Defined: a PARITY state follows DATA and decodes one extra bit. The XOR of the data bits and the parity bit must be 0 (even parity); a mismatch gives code 3, no valid, then IDLE. Decode failures inside PARITY use codes 1/2 as in DATA.
- Undefined: no PARITY state; DATA goes directly to STOP.

Decomposition:
- Shared package:
  - state enum: IDLE, START, DATA, PARITY, STOP.
  - error code constants: ERR_NONE = 0, ERR_MANCH = 1, ERR_NOEDGE = 2, ERR_FRAME = 3.
- One sub-module: manchester_rx_sync (2-FF synchroniser plus rise/fall/any edge outputs), reusable by other pin inputs.

Test Plan (HALF_BIT = 8, WIDTH = 16, parity off unless stated):
- Send 0xA5C3 with ideal timing -> one valid pulse, data_out = 0xA5C3, error never high, busy falls after the pulse.
- Send 0x1234 with the bit period stretched +10% -> valid, data_out = 0x1234 (resync tracks drift).
- Force data bit 5 to have no mid-bit transition -> error pulse, error_code = 2, data_out keeps its previous value, next frame 0x00FF is received correctly.
- 3-cycle high glitch on an idle line -> no valid, no error, busy returns to 0 within 2*HALF_BIT+3 cycles.
- Hold the line high through the stop interval -> error, error_code = 3. Assert rst mid-frame -> all outputs 0 immediately, no pulse.
- With MANCHESTER_RX_PARITY_EN: 0x0001 with parity 1 -> valid; 0x0001 with parity 0 -> error_code = 3.
